jtframe_vtgen: RTL and testbench

- Pixel-rate video timing generator: free-running horizontal/vertical counters with blanking, sync and frame-strobe flags.
- Sits directly upstream of the shift-register delay stage: its 5-bit sync bundle is the delay line's din, so sync/blank align with pipelined pixel data.
- Used by every core that needs raster timing; one instance per video domain.

---
 rtl/jtframe_video_pkg.sv | 41 ++++
 rtl/jtframe_vtgen_if.sv | 31 +++
 rtl/jtframe_vtgen_win.sv | 36 +++
 rtl/jtframe_vtgen.sv | 110 +++++++++++
 tb/tb_jtframe_vtgen.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/jtframe_video_pkg.sv
`default_nettype none
// ============================================================================
// Module   : jtframe_video_pkg
// Brief    : Default 384x264 raster timing and sync_bus bit positions.
// Revision : 1.0
// ============================================================================
package jtframe_video_pkg;

  localparam int c_hw       = 9;
  localparam int c_vw       = 9;
  localparam int c_h_start  = 0;
  localparam int c_h_end    = 383;
  localparam int c_hb_start = 256;
  localparam int c_hb_end   = 0;
  localparam int c_hs_start = 288;
  localparam int c_hs_end   = 320;
  localparam int c_v_start  = 0;
  localparam int c_v_end    = 263;
  localparam int c_vb_start = 224;
  localparam int c_vb_end   = 0;
  localparam int c_vs_start = 240;
  localparam int c_vs_end   = 244;

  localparam int c_sync_w   = 5;
  localparam int c_sb_lhbl  = 4;
  localparam int c_sb_lvbl  = 3;
  localparam int c_sb_hs    = 2;
  localparam int c_sb_vs    = 1;
  localparam int c_sb_frame = 0;

  // Half-open [s,e) window; s>e wraps around the counter end, s==e is empty.
  function automatic logic in_window(input logic [31:0] v,
                                     input logic [31:0] s,
                                     input logic [31:0] e);
    if (s == e)     return 1'b0;
    else if (s < e) return (v >= s) && (v < e);
    else            return (v >= s) || (v < e);
  endfunction

endpackage
`default_nettype wire

// File: rtl/jtframe_vtgen_if.sv
`default_nettype none
// ============================================================================
// Module   : jtframe_vtgen_if
// Brief    : Pixel enable in, raster counters and sync flags out.
// Revision : 1.0
// ============================================================================
interface jtframe_vtgen_if #(
  parameter int HW = 9,
  parameter int VW = 9
);
  logic          pxl_cen;
  logic [HW-1:0] H;
  logic [VW-1:0] V;
  logic          LHBL;
  logic          LVBL;
  logic          HS;
  logic          VS;
  logic          frame;
  logic [4:0]    sync_bus;

  modport master (
    input  pxl_cen,
    output H, V, LHBL, LVBL, HS, VS, frame, sync_bus
  );

  modport slave (
    output pxl_cen,
    input  H, V, LHBL, LVBL, HS, VS, frame, sync_bus
  );
endinterface
`default_nettype wire

// File: rtl/jtframe_vtgen_win.sv
`default_nettype none
// ============================================================================
// Module   : jtframe_vtgen_win
// Brief    : Registered in-window flag for a counter value, wrap-aware.
// Revision : 1.0
// ============================================================================
module jtframe_vtgen_win
  import jtframe_video_pkg::*;
#(
  parameter int W          = 9,
  parameter int START      = 0,
  parameter int END        = 0,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  wire logic         clk,
  input  wire logic         rst,
  input  wire logic         cen,
  input  wire logic         en,
  input  wire logic [W-1:0] value,
  output logic              flag
);

  logic w_in;

  assign w_in = in_window(32'(value), 32'(START), 32'(END));

  // Blanking flags are active-low, so the window result is inverted there.
  always_ff @(posedge clk) begin
    if (rst)
      flag <= 1'b0;
    else if (cen && en)
      flag <= w_in ^ ACTIVE_LOW;
  end

endmodule
`default_nettype wire

// File: rtl/jtframe_vtgen.sv
`default_nettype none
// ============================================================================
// Module   : jtframe_vtgen
// Brief    : Free-running H/V raster counters with blank, sync, frame flags.
// Revision : 1.0
// ============================================================================
module jtframe_vtgen
  import jtframe_video_pkg::*;
#(
  parameter int HW       = c_hw,
  parameter int VW       = c_vw,
  parameter int H_START  = c_h_start,
  parameter int H_END    = c_h_end,
  parameter int HB_START = c_hb_start,
  parameter int HB_END   = c_hb_end,
  parameter int HS_START = c_hs_start,
  parameter int HS_END   = c_hs_end,
  parameter int V_START  = c_v_start,
  parameter int V_END    = c_v_end,
  parameter int VB_START = c_vb_start,
  parameter int VB_END   = c_vb_end,
  parameter int VS_START = c_vs_start,
  parameter int VS_END   = c_vs_end
) (
  input wire logic        clk,
  input wire logic        rst,
  jtframe_vtgen_if.master vt
);

  generate
    if (H_START > H_END || H_END >= (1 << HW) ||
        V_START > V_END || V_END >= (1 << VW)) begin : g_param_bad
      $error("jtframe_vtgen: need H_START<=H_END<2**HW and V_START<=V_END<2**VW");
    end
  endgenerate

  logic [HW-1:0]       r_h;
  logic [VW-1:0]       r_v;
  logic                r_frame;
  logic [HW-1:0]       w_h_next;
  logic [VW-1:0]       w_v_next;
  logic                w_hwrap;
  logic                w_cen;
  logic                w_lhbl;
  logic                w_lvbl;
  logic                w_hs;
  logic                w_vs;
  logic [c_sync_w-1:0] w_sync;

  assign w_cen = vt.pxl_cen;

  always_comb begin
    w_hwrap  = (r_h == HW'(H_END));
    w_h_next = w_hwrap ? HW'(H_START) : r_h + 1'b1;
    w_v_next = r_v;
    if (w_hwrap)
      w_v_next = (r_v == VW'(V_END)) ? VW'(V_START) : r_v + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_h     <= HW'(H_START);
      r_v     <= VW'(V_START);
      r_frame <= 1'b0;
    end else if (w_cen) begin
      r_h     <= w_h_next;
      r_v     <= w_v_next;
      // Only a wrap can land on the frame origin; reset release steps past it.
      r_frame <= (w_h_next == HW'(H_START)) && (w_v_next == VW'(V_START));
    end
  end

  jtframe_vtgen_win #(.W(HW), .START(HB_START), .END(HB_END), .ACTIVE_LOW(1'b1)) u_lhbl (
    .clk(clk), .rst(rst), .cen(w_cen), .en(1'b1), .value(w_h_next), .flag(w_lhbl)
  );

  jtframe_vtgen_win #(.W(VW), .START(VB_START), .END(VB_END), .ACTIVE_LOW(1'b1)) u_lvbl (
    .clk(clk), .rst(rst), .cen(w_cen), .en(1'b1), .value(w_v_next), .flag(w_lvbl)
  );

  jtframe_vtgen_win #(.W(HW), .START(HS_START), .END(HS_END), .ACTIVE_LOW(1'b0)) u_hs (
    .clk(clk), .rst(rst), .cen(w_cen), .en(1'b1), .value(w_h_next), .flag(w_hs)
  );

  // VS only re-evaluates on the HS leading edge so both syncs change together.
  jtframe_vtgen_win #(.W(VW), .START(VS_START), .END(VS_END), .ACTIVE_LOW(1'b0)) u_vs (
    .clk(clk), .rst(rst), .cen(w_cen), .en(w_h_next == HW'(HS_START)),
    .value(w_v_next), .flag(w_vs)
  );

  always_comb begin
    w_sync             = '0;
    w_sync[c_sb_lhbl]  = w_lhbl;
    w_sync[c_sb_lvbl]  = w_lvbl;
    w_sync[c_sb_hs]    = w_hs;
    w_sync[c_sb_vs]    = w_vs;
    w_sync[c_sb_frame] = r_frame;
  end

  assign vt.H        = r_h;
  assign vt.V        = r_v;
  assign vt.LHBL     = w_lhbl;
  assign vt.LVBL     = w_lvbl;
  assign vt.HS       = w_hs;
  assign vt.VS       = w_vs;
  assign vt.frame    = r_frame;
  assign vt.sync_bus = w_sync;

endmodule
`default_nettype wire

// File: tb/tb_jtframe_vtgen.sv
`default_nettype none
// ============================================================================
// Module   : tb_jtframe_vtgen
// Brief    : Bench for jtframe_vtgen: default timing plus a wrapped-blank,
//            short-frame instance, checked against a cen-count raster model.
// Revision : 1.0
// ============================================================================
module tb_jtframe_vtgen;

  typedef struct {
    int h_start, h_end, hb_s, hb_e, hs_s, hs_e;
    int v_start, v_end, vb_s, vb_e, vs_s, vs_e;
  } timing_t;

  typedef struct {
    int h, v;
    bit lhbl, lvbl, hs, vs, frame;
  } exp_t;

  logic clk;
  logic rst;
  logic cen;
  int   errors;
  int   checks;
  int   n;       // pxl_cen edges since last reset
  int   cyc;
  timing_t ta, tbt;

  jtframe_vtgen_if #(.HW(9), .VW(9)) if_a ();
  jtframe_vtgen_if #(.HW(9), .VW(9)) if_b ();

  assign if_a.pxl_cen = cen;
  assign if_b.pxl_cen = cen;

  jtframe_vtgen dut_a (
    .clk(clk), .rst(rst), .vt(if_a)
  );

  jtframe_vtgen #(
    .HB_START(370), .HB_END(10),
    .V_END(19), .VB_START(14), .VB_END(2), .VS_START(16), .VS_END(3)
  ) dut_b (
    .clk(clk), .rst(rst), .vt(if_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit win(int v, int s, int e);
    if (s == e) return 1'b0;
    if (s < e)  return (v >= s && v < e);
    return (v >= s || v < e);
  endfunction

  // Position is pure arithmetic on the enable count since reset.
  function automatic exp_t model(timing_t t, int cnt);
    exp_t e;
    int len, nv, h_off, line, hs_off;
    len    = t.h_end - t.h_start + 1;
    nv     = t.v_end - t.v_start + 1;
    h_off  = cnt % len;
    line   = cnt / len;
    hs_off = t.hs_s - t.h_start;
    e.h = t.h_start + h_off;
    e.v = t.v_start + (line % nv);
    e.lhbl = 0; e.lvbl = 0; e.hs = 0; e.vs = 0; e.frame = 0;
    if (cnt == 0) return e;
    e.lhbl  = !win(e.h, t.hb_s, t.hb_e);
    e.lvbl  = !win(e.v, t.vb_s, t.vb_e);
    e.hs    = win(e.h, t.hs_s, t.hs_e);
    e.frame = (h_off == 0) && ((line % nv) == 0);
    // VS is whatever the line was at the most recent HS leading edge.
    if (h_off >= hs_off && !(line == 0 && hs_off == 0))
      e.vs = win(e.v, t.vs_s, t.vs_e);
    else if (line > 0)
      e.vs = win(t.v_start + ((line - 1) % nv), t.vs_s, t.vs_e);
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d (cen count %0d)", tag, obs, exp, n);
    end
  endtask

  task automatic check_dut(input string p, input logic [8:0] hh, input logic [8:0] vv,
                           input logic lh, input logic lv, input logic hs, input logic vs,
                           input logic fr, input logic [4:0] sb, input exp_t e);
    chk({p, "_H"}, 32'(hh), 32'(e.h));
    chk({p, "_V"}, 32'(vv), 32'(e.v));
    chk({p, "_LHBL"}, 32'(lh), 32'(e.lhbl));
    chk({p, "_LVBL"}, 32'(lv), 32'(e.lvbl));
    chk({p, "_HS"}, 32'(hs), 32'(e.hs));
    chk({p, "_VS"}, 32'(vs), 32'(e.vs));
    chk({p, "_frame"}, 32'(fr), 32'(e.frame));
    chk({p, "_sync_bus"}, 32'(sb), 32'({e.lhbl, e.lvbl, e.hs, e.vs, e.frame}));
  endtask

  task automatic step(input bit c, input bit r);
    @(negedge clk);
    cen = c;
    rst = r;
    @(posedge clk);
    if (r)      n = 0;
    else if (c) n++;
    cyc++;
    #1;
    check_dut("a", if_a.H, if_a.V, if_a.LHBL, if_a.LVBL, if_a.HS, if_a.VS,
              if_a.frame, if_a.sync_bus, model(ta, n));
    check_dut("b", if_b.H, if_b.V, if_b.LHBL, if_b.LVBL, if_b.HS, if_b.VS,
              if_b.frame, if_b.sync_bus, model(tbt, n));
  endtask

  initial begin
    int  last_fr;
    int  first_wrap;
    bit  prev_bfr;
    bit  found;
    logic [8:0] prev_ah;

    errors = 0; checks = 0; n = 0; cyc = 0;
    cen = 1'b0; rst = 1'b1;
    ta  = '{0, 383, 256, 0, 288, 320, 0, 263, 224, 0, 240, 244};
    tbt = '{0, 383, 370, 10, 288, 320, 0, 19, 14, 2, 16, 3};

    // Reset holds regardless of pxl_cen.
    for (int i = 0; i < 4; i++) step(1'($urandom_range(0, 1)), 1'b1);

    // Back-to-back enables: two full short frames of dut_b.
    last_fr  = -1;
    prev_bfr = 1'b0;
    for (int i = 0; i < 2 * 7680 + 400; i++) begin
      step(1'b1, 1'b0);
      if (if_b.frame && !prev_bfr) begin
        if (last_fr >= 0) chk("b_frame_gap", 32'(n - last_fr), 32'd7680);
        last_fr = n;
      end
      prev_bfr = if_b.frame;
    end
    chk("b_frame_seen", 32'(last_fr), 32'd15360);

    // One enable in four: line must take exactly 384*4 clocks.
    first_wrap = -1;
    prev_ah    = if_a.H;
    for (int k = 0; k < 3 * 1536; k++) begin
      step(k % 4 == 0, 1'b0);
      if (if_a.H == 9'd0 && prev_ah != 9'd0) begin
        if (first_wrap >= 0 && first_wrap != -2) begin
          chk("a_line_clks", 32'(cyc - first_wrap), 32'd1536);
          first_wrap = -2;
        end else if (first_wrap == -1) begin
          first_wrap = cyc;
        end
      end
      prev_ah = if_a.H;
    end
    chk("a_line_measured", 32'(first_wrap), 32'hFFFF_FFFE);

    // Random enables with occasional resets.
    for (int i = 0; i < 3000; i++)
      step(1'($urandom_range(0, 1)), $urandom_range(0, 499) == 0);

    // Mid-line reset at H=150.
    found = 1'b0;
    for (int i = 0; i < 1000 && !found; i++) begin
      step(1'b1, 1'b0);
      if (if_a.H == 9'd150) found = 1'b1;
    end
    chk("a_reach_h150", 32'(found), 32'd1);
    step(1'($urandom_range(0, 1)), 1'b1);
    chk("rst_mid_H", 32'(if_a.H), 32'd0);
    chk("rst_mid_V", 32'(if_a.V), 32'd0);
    chk("rst_mid_bus", 32'(if_a.sync_bus), 32'd0);
    step(1'b1, 1'b0);
    chk("rst_resume_H", 32'(if_a.H), 32'd1);
    for (int i = 0; i < 500; i++) step(1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
